// File: rtl/div_pkg_3.sv
// div_pkg_3: widths, state encoding and constants for the iterative divider
package div_pkg_3;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W = 8;
  localparam int CNT_W = $clog2(DIVIDEND_W);
  typedef enum logic {IDLE, CALC} state_t;
  localparam logic [DIVIDEND_W-1:0] DIV0_Q = '1;
endpackage

// File: rtl/div_step_3.sv
// div_step_3: one restoring-division step, shift in a bit and conditionally subtract
module div_step_3
  import div_pkg_3::*;
(
  input  logic [DIVISOR_W:0]   r,
  input  logic                 q_in,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 q_bit
);
  logic [DIVISOR_W+1:0] rs;
  always_comb begin
    rs = {r, q_in};
    q_bit = rs >= {2'b00, d};
    r_next = q_bit ? (DIVISOR_W+1)'(rs - {2'b00, d}) : rs[DIVISOR_W:0];
  end
endmodule

// File: rtl/div_iter_3.sv
// div_iter_3: 16/8 unsigned iterative restoring divider, one quotient bit per clock
module div_iter_3
  import div_pkg_3::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  result_rdy,
  output logic                  busy,
  output logic                  div_by_zero
);
  state_t state;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0] d;
  logic [DIVISOR_W:0] r, r_next;
  logic [CNT_W-1:0] cnt;
  logic dz, q_bit;
  logic [DIVIDEND_W-1:0] q_next;
  div_step_3 u_step (
    .r      (r),
    .q_in   (q[DIVIDEND_W-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );
  assign q_next = {q[DIVIDEND_W-2:0], q_bit};
  assign busy = state == CALC;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      dz <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      result_rdy <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      if (state == IDLE) begin
        if (en) begin
          q <= dividend;
          d <= divisor;
          r <= '0;
          cnt <= '0;
          dz <= divisor == '0;
          state <= CALC;
        end
      end else begin
        q <= q_next;
        r <= r_next;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIVIDEND_W-1)) begin
          state <= IDLE;
          result_rdy <= 1'b1;
          quotient <= dz ? DIV0_Q : q_next;
          remainder <= dz ? '0 : r_next[DIVISOR_W-1:0];
          div_by_zero <= dz;
        end
      end
    end
endmodule

// File: tb/tb_div_iter_3.sv
// tb_div_iter_3: scoreboard bench for div_iter_3 with directed vectors
module tb_div_iter_3;
  logic clk = 0, rst, en;
  logic [15:0] dividend, quotient;
  logic [7:0] divisor, remainder;
  logic result_rdy, busy, div_by_zero;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {logic [15:0] q; logic [7:0] r; logic dz; int t;} exp_t;
  exp_t sb[$];
  div_iter_3 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .result_rdy  (result_rdy),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (result_rdy) begin
      chk("rdy_busy_exclusive", {31'd0, busy}, 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: got result_rdy=1 expected 0 (q=%0d)", quotient);
      end else begin
        e = sb.pop_front();
        chk("quotient", {16'd0, quotient}, {16'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency_cycle", cyc, e.t);
      end
    end
  end
  // drives en for one edge; caller positions at a negedge
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz);
    en = 1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{eq, er, edz, cyc + 16});
    en = 0;
    dividend = $urandom;
    divisor = $urandom;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, {16'd0, quotient}, 0);
    chk({tag, "_remainder"}, {24'd0, remainder}, 0);
    chk({tag, "_result_rdy"}, {31'd0, result_rdy}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 0);
  endtask
  logic [15:0] va [8] = '{1000, 65535, 65535, 5, 0, 1234, 20, 0};
  logic [7:0]  vb [8] = '{7, 255, 1, 9, 3, 0, 6, 0};
  logic [15:0] vq [8] = '{142, 257, 65535, 0, 0, 16'hFFFF, 3, 0};
  logic [7:0]  vr [8] = '{6, 0, 0, 5, 0, 0, 2, 0};
  logic        vz [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  initial begin
    rst = 1;
    en = 0;
    dividend = 0;
    divisor = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      issue(va[i], vb[i], 1, vq[i], vr[i], vz[i]);
      wait_idle();
    end
    @(negedge clk);
    issue(100, 10, 1, 10, 0, 0);
    repeat (4) @(negedge clk);
    issue(50, 5, 0, 0, 0, 0);
    for (int i = 0; i < 40 && !result_rdy; i++) @(negedge clk);
    issue(50, 5, 1, 10, 0, 0);
    wait_idle();
    @(negedge clk);
    issue(300, 7, 0, 0, 0, 0);
    repeat (7) @(negedge clk);
    rst = 1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 0;
    repeat (25) @(negedge clk);
    chk_zero("post_abort");
    issue(300, 7, 1, 42, 6, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
